id_ex_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 38 +++
 rtl/hazard_detect.sv | 27 ++
 rtl/id_ex_reg.sv | 108 ++++++++++
 tb/tb_id_ex_reg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, bubble constant and
// default datapath/register-index widths.
package pipe_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned RW_DEFAULT = 5;
    localparam int unsigned CTRL_W     = 12;
    localparam int unsigned ALUOP_W    = 5;
    localparam int unsigned FF_W       = 6;
    localparam int unsigned CNT_W      = 16;

    // Bit positions inside the control bundle
    localparam int unsigned CTRL_ALUOP_HI = 11;
    localparam int unsigned CTRL_ALUOP_LO = 7;
    localparam int unsigned CTRL_ALUSRC   = 6;
    localparam int unsigned CTRL_REGDST   = 5;
    localparam int unsigned CTRL_MEMREAD  = 4;
    localparam int unsigned CTRL_MEMWRITE = 3;
    localparam int unsigned CTRL_MEMTOREG = 2;
    localparam int unsigned CTRL_REGWRITE = 1;
    localparam int unsigned CTRL_BRANCH   = 0;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               reg_dst;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               reg_write;
        logic               branch;
    } ctrl_t;

    // All-zero control: no writes, no memory access, no branch
    localparam logic [CTRL_W-1:0] CTRL_NOP = 12'h000;
    localparam logic [CNT_W-1:0]  CNT_MAX  = 16'hFFFF;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector.
// Flags a stall when the instruction in EX is a valid load whose destination
// (rt, not $zero) is a source of the valid instruction currently in ID.
// Ports: ex_valid, ex_mem_read, ex_rt (EX side); id_valid, id_rs, id_rt (ID
// side); load_use_c (combinational stall request).
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int unsigned RW = RW_DEFAULT
) (
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rt,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    output logic          load_use_c
);

    logic rt_nonzero;
    logic rt_match;

    assign rt_nonzero = (ex_rt != RW'(0));
    assign rt_match   = (ex_rt == id_rs) | (ex_rt == id_rt);
    assign load_use_c = ex_valid & ex_mem_read & rt_nonzero & id_valid & rt_match;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall (hold), flush (bubble) and a saturating
// bubble counter. Optional built-in load-use detection is compiled in when
// ID_EX_LOAD_USE_DETECT_EN is defined; otherwise hazard_stall is tied to 0 and
// bubbles come only from flush.
// Ports: clk, reset (async, active-high); stall, flush; id_* decoded
// instruction in; ex_* registered instruction out (ex_aluOp/ex_ff are slices
// of ex_ctrl/ex_imm); hazard_stall combinational load-use request;
// bubble_cnt saturating count of inserted bubbles.
module id_ex_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned RW = RW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [DW-1:0]      id_pc4,
    input  logic [DW-1:0]      id_rs_data,
    input  logic [DW-1:0]      id_rt_data,
    input  logic [DW-1:0]      id_imm,
    input  logic [RW-1:0]      id_rs,
    input  logic [RW-1:0]      id_rt,
    input  logic [RW-1:0]      id_rd,
    output logic               ex_valid,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [ALUOP_W-1:0] ex_aluOp,
    output logic [FF_W-1:0]    ex_ff,
    output logic [DW-1:0]      ex_pc4,
    output logic [DW-1:0]      ex_rs_data,
    output logic [DW-1:0]      ex_rt_data,
    output logic [DW-1:0]      ex_imm,
    output logic [RW-1:0]      ex_rs,
    output logic [RW-1:0]      ex_rt,
    output logic [RW-1:0]      ex_rd,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   bubble_cnt
);

    ctrl_t ctrl_q;
    logic  bubble;

    assign ex_ctrl  = ctrl_q;
    assign ex_aluOp = ctrl_q.alu_op;
    assign ex_ff    = ex_imm[FF_W-1:0];

`ifdef ID_EX_LOAD_USE_DETECT_EN
    hazard_detect #(
        .RW (RW)
    ) u_hazard_detect (
        .ex_valid    (ex_valid),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rt       (ex_rt),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .load_use_c  (hazard_stall)
    );
`else
    assign hazard_stall = 1'b0;
`endif

    // Flush wins over stall; a load-use bubble only when not externally stalled
    assign bubble = flush | (hazard_stall & ~stall);

    // Pipeline register: reset > bubble (flush) > stall > bubble (hazard) > load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ctrl_q     <= ctrl_t'(CTRL_NOP);
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            bubble_cnt <= '0;
        end else if (bubble) begin
            ex_valid   <= 1'b0;
            ctrl_q     <= ctrl_t'(CTRL_NOP);
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            if (bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 16'd1;
            end
        end else if (!stall) begin
            ex_valid   <= id_valid;
            ctrl_q     <= ctrl_t'(id_ctrl);
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg. Expectations for load-use
// behaviour follow whether ID_EX_LOAD_USE_DETECT_EN is defined.
module tb_id_ex_reg;

`ifdef ID_EX_LOAD_USE_DETECT_EN
    localparam bit LU = 1'b1;
`else
    localparam bit LU = 1'b0;
`endif

    localparam logic [11:0] C_RTYPE = 12'h122; // aluOp=00010, regDst, regWrite
    localparam logic [11:0] C_LW    = 12'h056; // aluSrc, memRead, memToReg, regWrite

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [11:0] id_ctrl;
    logic [31:0] id_pc4;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        ex_valid;
    logic [11:0] ex_ctrl;
    logic [4:0]  ex_aluOp;
    logic [5:0]  ex_ff;
    logic [31:0] ex_pc4;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic        hazard_stall;
    logic [15:0] bubble_cnt;

    int          vectors = 0;
    int          errs    = 0;
    logic [15:0] exp_cnt;
    logic        exp_haz;
    logic [11:0] exp_ctrl;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_pc4       (id_pc4),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_aluOp     (ex_aluOp),
        .ex_ff        (ex_ff),
        .ex_pc4       (ex_pc4),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .hazard_stall (hazard_stall),
        .bubble_cnt   (bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge and come to rest on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [11:0] c, input logic [31:0] pc4,
                         input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v; id_ctrl = c; id_pc4 = pc4; id_rs_data = rsd; id_rt_data = rtd;
        id_imm = imm; id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},  64'(ex_valid),     64'(0));
        chk({tag, ".ctrl"},   64'(ex_ctrl),      64'(0));
        chk({tag, ".pc4"},    64'(ex_pc4),       64'(0));
        chk({tag, ".rsdata"}, 64'(ex_rs_data),   64'(0));
        chk({tag, ".rtdata"}, 64'(ex_rt_data),   64'(0));
        chk({tag, ".imm"},    64'(ex_imm),       64'(0));
        chk({tag, ".rd"},     64'(ex_rd),        64'(0));
        chk({tag, ".cnt"},    64'(bubble_cnt),   64'(0));
        chk({tag, ".haz"},    64'(hazard_stall), 64'(0));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        exp_haz = LU;
        repeat (2) tick();
        chk_zero("reset_init");
        reset = 1'b0;

        // R-type load: aluOp 00010, funct 100010
        drive(1'b1, C_RTYPE, 32'h0000_0104, 32'hAAAA_0001, 32'h5555_0002, 32'h0000_0022,
              5'd1, 5'd2, 5'd3);
        tick();
        chk("rtype.aluop", 64'(ex_aluOp),   64'(5'b00010));
        chk("rtype.ff",    64'(ex_ff),      64'(6'b100010));
        chk("rtype.ctrl",  64'(ex_ctrl),    64'(C_RTYPE));
        chk("rtype.valid", 64'(ex_valid),   64'(1));
        chk("rtype.pc4",   64'(ex_pc4),     64'(32'h0000_0104));
        chk("rtype.rsd",   64'(ex_rs_data), 64'(32'hAAAA_0001));
        chk("rtype.rtd",   64'(ex_rt_data), 64'(32'h5555_0002));
        chk("rtype.idx",   64'({ex_rs, ex_rt, ex_rd}), 64'({5'd1, 5'd2, 5'd3}));
        chk("rtype.cnt",   64'(bubble_cnt), 64'(0));

        // Stall three cycles while ID changes: EX holds
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 12'hFFF - 12'(i), 32'h1000 + 32'(i), 32'hDEAD_0000 + 32'(i), 32'hBEEF_0000,
                  32'h0000_FFFF, 5'd9, 5'd10, 5'(i + 11));
            tick();
            chk("stall.ctrl", 64'(ex_ctrl),    64'(C_RTYPE));
            chk("stall.rsd",  64'(ex_rs_data), 64'(32'hAAAA_0001));
            chk("stall.rd",   64'(ex_rd),      64'(3));
            chk("stall.cnt",  64'(bubble_cnt), 64'(0));
        end

        // Stall together with flush: bubble wins
        flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        chk("stflush.valid", 64'(ex_valid),   64'(0));
        chk("stflush.ctrl",  64'(ex_ctrl),    64'(0));
        chk("stflush.rsd",   64'(ex_rs_data), 64'(0));
        chk("stflush.imm",   64'(ex_imm),     64'(0));
        chk("stflush.cnt",   64'(bubble_cnt), 64'(1));
        exp_cnt = 16'd1;

        // Invalid instruction is still a load, not a bubble
        drive(1'b0, 12'h0FF, 32'h0000_0200, 32'h1111_1111, 32'h2222_2222, 32'h0000_0033,
              5'd4, 5'd5, 5'd6);
        tick();
        chk("inval.valid", 64'(ex_valid),   64'(0));
        chk("inval.ctrl",  64'(ex_ctrl),    64'(12'h0FF));
        chk("inval.rtd",   64'(ex_rt_data), 64'(32'h2222_2222));
        chk("inval.rd",    64'(ex_rd),      64'(6));
        chk("inval.cnt",   64'(bubble_cnt), 64'(exp_cnt));

        // Load-use: lw writing $8 in EX, ID reads $8 as rs
        drive(1'b1, C_LW, 32'h0000_0300, 32'h0, 32'h0, 32'h0000_0010, 5'd4, 5'd8, 5'd0);
        tick();
        drive(1'b1, C_RTYPE, 32'h0000_0304, 32'h3, 32'h4, 32'h0000_0022, 5'd8, 5'd9, 5'd10);
        #1;
        chk("lu.haz", 64'(hazard_stall), 64'(exp_haz));
        tick();
        exp_ctrl = LU ? 12'h000 : C_RTYPE;
        exp_cnt  = exp_cnt + 16'(LU);
        chk("lu.valid", 64'(ex_valid),     64'(!LU));
        chk("lu.ctrl",  64'(ex_ctrl),      64'(exp_ctrl));
        chk("lu.haz2",  64'(hazard_stall), 64'(0));
        chk("lu.cnt",   64'(bubble_cnt),   64'(exp_cnt));
        tick();
        chk("lu.reload.ctrl", 64'(ex_ctrl), 64'(C_RTYPE));
        chk("lu.reload.rs",   64'(ex_rs),   64'(8));

        // $zero destination never raises a hazard
        drive(1'b1, C_LW, 32'h0000_0400, 32'h0, 32'h0, 32'h0, 5'd4, 5'd0, 5'd0);
        tick();
        drive(1'b1, C_RTYPE, 32'h0000_0404, 32'h5, 32'h6, 32'h0000_0022, 5'd0, 5'd0, 5'd7);
        #1;
        chk("zero.haz", 64'(hazard_stall), 64'(0));
        tick();
        chk("zero.valid", 64'(ex_valid),   64'(1));
        chk("zero.ctrl",  64'(ex_ctrl),    64'(C_RTYPE));
        chk("zero.cnt",   64'(bubble_cnt), 64'(exp_cnt));

        // Hazard with external stall holds; then hazard with flush counts once
        drive(1'b1, C_LW, 32'h0000_0500, 32'h0, 32'h0, 32'h0, 5'd4, 5'd8, 5'd0);
        tick();
        drive(1'b1, C_RTYPE, 32'h0000_0504, 32'h7, 32'h8, 32'h0000_0022, 5'd1, 5'd8, 5'd11);
        stall = 1'b1;
        tick();
        chk("hzstall.ctrl", 64'(ex_ctrl),      64'(C_LW));
        chk("hzstall.cnt",  64'(bubble_cnt),   64'(exp_cnt));
        chk("hzstall.haz",  64'(hazard_stall), 64'(exp_haz));
        stall = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("hzflush.valid", 64'(ex_valid),   64'(0));
        chk("hzflush.cnt",   64'(bubble_cnt), 64'(exp_cnt));

        // Reset asserted mid-stall clears everything immediately
        drive(1'b1, C_LW, 32'h0000_0600, 32'h9, 32'hA, 32'h0000_0022, 5'd4, 5'd8, 5'd12);
        tick();
        drive(1'b1, C_RTYPE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              5'd8, 5'd8, 5'd31);
        stall = 1'b1; flush = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;
        tick();
        chk("postreset.valid", 64'(ex_valid), 64'(1));
        chk("postreset.ctrl",  64'(ex_ctrl),  64'(C_RTYPE));
        chk("postreset.pc4",   64'(ex_pc4),   64'(32'hFFFF_FFFF));
        chk("postreset.cnt",   64'(bubble_cnt), 64'(0));

        // Counter saturation: 65535 flushes then one more
        flush = 1'b1;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        chk("sat.full", 64'(bubble_cnt), 64'(16'hFFFF));
        tick();
        chk("sat.hold", 64'(bubble_cnt), 64'(16'hFFFF));
        chk("sat.valid", 64'(ex_valid), 64'(0));
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
